fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Instruction fetch front end that sits directly upstream of the instruction memory and drives its address and FETCH strobe. It holds the program counter and, for instructions that carry one operand byte, reads that second byte too. It presents each assembled instruction to the decoder over a valid/ready handshake. It also handles PC loads (jumps) from the decoder and halts on a HALT opcode.

Parameters:
RESET_PC, 8'h00, PC value after reset
OPERAND_MASK, 8'h80, opcode bits that mark a 2-byte instruction (any masked bit set -> operand byte follows)
HALT_OPCODE, 8'h00, opcode that halts fetching

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE and begin fetching at current PC
iAddr  out  8  instruction memory address; always equals pc
FETCH  out  1  instruction memory read strobe
instr  in  8  instruction memory data, valid the cycle after FETCH
ir_opcode  out  8  opcode of the issued instruction
ir_operand  out  8  operand byte (8'h00 for 1-byte instructions)
ir_valid  out  1  issued instruction valid
ir_ready  in  1  decoder accepts the instruction
pc_load  in  1  load PC (jump/branch)
pc_load_addr  in  8  new PC value
halted  out  1  high while in HALT
pc  out  8  current program counter

Behaviour:
- Reset (asynchronous, when rst_n=0):
  - pc=RESET_PC, iAddr=RESET_PC, FETCH=0, ir_opcode=0, ir_operand=0, ir_valid=0, halted=0.
  - State goes to IDLE. This applies mid-operation too; any in-flight fetch is abandoned.
- FETCH is a combinational decode of the state: 1 only in OP_REQ and ARG_REQ. iAddr = pc at all times.
- States:
  - IDLE: FETCH=0. If start=1 -> OP_REQ. start is ignored in every other state.
  - OP_REQ: FETCH=1. pc<=pc+1. -> OP_CAP.
  - OP_CAP: ir_opcode<=instr.
    - If instr==HALT_OPCODE -> HALT, halted<=1.
    - Else if (instr & OPERAND_MASK)!=0 -> ARG_REQ.
    - Else ir_operand<=0, ir_valid<=1 -> ISSUE.
    - HALT_OPCODE takes precedence over the mask test.
  - ARG_REQ: FETCH=1. pc<=pc+1. -> ARG_CAP.
  - ARG_CAP: ir_operand<=instr, ir_valid<=1. -> ISSUE.
  - ISSUE: ir_valid=1. ir_opcode and ir_operand are held stable; FETCH=0.
    - If ir_ready=1: ir_valid<=0 -> OP_REQ.
    - If ir_ready=0: stay in ISSUE indefinitely.
  - HALT: FETCH=0, halted=1. Exit only via pc_load or reset.
- Throughput: 1-byte instruction every 3 cycles; 2-byte instruction every 5 cycles (with ir_ready held high).
- Latency: after start is sampled, FETCH is high in the next cycle and ir_valid rises two cycles after that.
- pc_load has the highest priority and is honoured in every state, including IDLE and HALT:
  - Next edge: pc<=pc_load_addr, ir_valid<=0, halted<=0, state<=OP_REQ.
  - Any opcode/operand being captured that cycle is discarded and never issued.
  - pc_load in OP_REQ/ARG_REQ: FETCH is still high that cycle, but the returned byte is ignored.
  - pc_load together with ir_ready in ISSUE: the instruction counts as consumed, and the PC takes pc_load_addr.
- PC arithmetic is 8-bit modulo. 8'hFF+1 wraps to 8'h00, including an operand fetch across the wrap. There is no error flag.
- ir_opcode/ir_operand keep their last values when ir_valid=0.

Test Plan:
- Program mem[0..4]=01,02,03,04,05, mem[5]=00; ir_ready=1; pulse start -> FETCH pulses at iAddr 0,1,2,3,4,5 three cycles apart; ir_opcode 01..05 each with ir_operand=00; then halted=1, pc=06, FETCH stays 0.
- mem[0]=81, mem[1]=3C, mem[2]=00 -> one issue with ir_opcode=81, ir_operand=3C; FETCH seen at 00 and 01; then halt with pc=03.
- Backpressure: ir_ready=0 for 5 cycles at first issue -> ir_valid stays 1, ir_opcode=01 stable, FETCH=0, pc=01. On ir_ready=1, the next FETCH occurs at iAddr=01.
- pc_load=1, pc_load_addr=10 during OP_CAP of addr 00 -> opcode 01 never issued; next FETCH at iAddr=10. Repeat while in HALT -> halted drops, fetch resumes at 10.
- Wrap: pc_load to FF with mem[FF]=81, mem[00]=55 -> FETCH at FF then 00; ir_opcode=81, ir_operand=55; pc=01.
- Assert rst_n=0 in ARG_CAP -> all outputs return to reset values immediately, without a clock edge. After release there is no FETCH until start; then fetch begins at iAddr=00.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction fetch front end. Holds the program counter and drives the
// instruction memory address and read strobe. It reads one opcode byte,
// plus a second operand byte when the opcode calls for one, and presents
// the assembled instruction to the decoder over a valid/ready handshake.
// Jumps arrive from the decoder as PC loads, and a HALT opcode stops fetching.
//
// Ports:
//   clk           rising-edge clock for all state
//   rst_n         asynchronous active-low reset
//   start         leave IDLE and begin fetching at the current PC
//   iAddr         instruction memory address (always equals pc)
//   FETCH         instruction memory read strobe
//   instr         instruction memory data, valid the cycle after FETCH
//   ir_opcode     opcode of the issued instruction
//   ir_operand    operand byte (8'h00 for 1-byte instructions)
//   ir_valid      issued instruction valid
//   ir_ready      decoder accepts the instruction
//   pc_load       load the PC (jump/branch), highest priority
//   pc_load_addr  new PC value
//   halted        high while in HALT
//   pc            current program counter
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [7:0] RESET_PC     = 8'h00,
    parameter logic [7:0] OPERAND_MASK = 8'h80,
    parameter logic [7:0] HALT_OPCODE  = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] iAddr,
    output logic       FETCH,
    input  logic [7:0] instr,
    output logic [7:0] ir_opcode,
    output logic [7:0] ir_operand,
    output logic       ir_valid,
    input  logic       ir_ready,
    input  logic       pc_load,
    input  logic [7:0] pc_load_addr,
    output logic       halted,
    output logic [7:0] pc
);

    typedef enum logic [2:0] {
        IDLE,
        OP_REQ,
        OP_CAP,
        ARG_REQ,
        ARG_CAP,
        ISSUE,
        HALT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] pc_next;
    logic [7:0] opcode_next;
    logic [7:0] operand_next;
    logic       valid_next;
    logic       halted_next;

    // The memory strobe is a pure decode of the request states. The address
    // is the PC itself, so the byte returned the following cycle belongs to
    // the PC value held during the request (the PC has already advanced).
    assign FETCH = (state == OP_REQ) || (state == ARG_REQ);
    assign iAddr = pc;

    // State and datapath registers. Reset takes effect immediately and
    // drops any fetch that is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ir_opcode  <= 8'h00;
            ir_operand <= 8'h00;
            ir_valid   <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            ir_opcode  <= opcode_next;
            ir_operand <= operand_next;
            ir_valid   <= valid_next;
            halted     <= halted_next;
        end
    end

    // Next-state and next-datapath logic. Everything holds by default; each
    // state changes only what it owns. A PC load is applied last so that it
    // overrides whatever the current state decided, which discards any byte
    // being captured and any instruction being issued this cycle.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        opcode_next  = ir_opcode;
        operand_next = ir_operand;
        valid_next   = ir_valid;
        halted_next  = halted;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = OP_REQ;
                end
            end
            OP_REQ: begin
                pc_next    = pc + 8'd1;
                state_next = OP_CAP;
            end
            OP_CAP: begin
                opcode_next = instr;
                // The halt opcode wins even if it also matches the mask.
                if (instr == HALT_OPCODE) begin
                    halted_next = 1'b1;
                    state_next  = HALT;
                end else if ((instr & OPERAND_MASK) != 8'h00) begin
                    state_next = ARG_REQ;
                end else begin
                    operand_next = 8'h00;
                    valid_next   = 1'b1;
                    state_next   = ISSUE;
                end
            end
            ARG_REQ: begin
                pc_next    = pc + 8'd1;
                state_next = ARG_CAP;
            end
            ARG_CAP: begin
                operand_next = instr;
                valid_next   = 1'b1;
                state_next   = ISSUE;
            end
            ISSUE: begin
                if (ir_ready) begin
                    valid_next = 1'b0;
                    state_next = OP_REQ;
                end
            end
            HALT: begin
                halted_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (pc_load) begin
            pc_next     = pc_load_addr;
            valid_next  = 1'b0;
            halted_next = 1'b0;
            state_next  = OP_REQ;
            opcode_next = ir_opcode;
            operand_next = ir_operand;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer. A behavioural instruction memory
// answers FETCH one cycle later. A monitor on the falling edge logs every
// fetch address (with its cycle number) and every accepted instruction
// (opcode, operand, pc). Each scenario then compares those logs and the
// outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] iAddr;
    logic       FETCH;
    logic [7:0] instr;
    logic [7:0] ir_opcode;
    logic [7:0] ir_operand;
    logic       ir_valid;
    logic       ir_ready;
    logic       pc_load;
    logic [7:0] pc_load_addr;
    logic       halted;
    logic [7:0] pc;

    logic [7:0]  mem [256];
    logic [7:0]  fetchQ [$];
    int          fetchCyc [$];
    logic [23:0] issueQ [$];
    int          cycleCount = 0;
    int          fetchBase;
    int          issueBase;
    int          compared = 0;
    int          mismatched = 0;

    fetch_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .iAddr        (iAddr),
        .FETCH        (FETCH),
        .instr        (instr),
        .ir_opcode    (ir_opcode),
        .ir_operand   (ir_operand),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .halted       (halted),
        .pc           (pc)
    );

    always #5 clk = ~clk;

    // Cycle counter used to measure spacing between fetches.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Instruction memory: the byte at the strobed address appears next cycle.
    always @(posedge clk) begin
        if (FETCH) instr <= mem[iAddr];
    end

    // Falling-edge monitor logging fetches and accepted instructions.
    always @(negedge clk) begin
        if (rst_n) begin
            if (FETCH) begin
                fetchQ.push_back(iAddr);
                fetchCyc.push_back(cycleCount);
            end
            if (ir_valid && ir_ready) issueQ.push_back({ir_opcode, ir_operand, pc});
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start / pc_load for exactly one sampled edge, then release them.
    task automatic applyStimulus(input logic s, input logic ld, input logic [7:0] addr);
        start        = s;
        pc_load      = ld;
        pc_load_addr = addr;
        tick();
        start   = 1'b0;
        pc_load = 1'b0;
    endtask

    task automatic resetDut();
        rst_n        = 1'b0;
        start        = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = 8'h00;
        ir_ready     = 1'b1;
        foreach (mem[i]) mem[i] = 8'h00;
        tick();
        rst_n     = 1'b1;
        fetchBase = fetchQ.size();
        issueBase = issueQ.size();
    endtask

    task automatic waitHalted(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        checkOutput("halted_reached", {31'd0, halted}, 32'd1);
    endtask

    task automatic waitValid(input int budget);
        int n = 0;
        while (!ir_valid && n < budget) begin
            tick();
            n++;
        end
        checkOutput("valid_reached", {31'd0, ir_valid}, 32'd1);
    endtask

    task automatic checkFetchAt(input int idx, input logic [7:0] addr);
        if (fetchBase + idx < fetchQ.size())
            checkOutput("fetch_addr", {24'd0, fetchQ[fetchBase + idx]}, {24'd0, addr});
        else
            checkOutput("fetch_missing", 32'd0, 32'd1);
    endtask

    task automatic checkIssueAt(input int idx, input logic [23:0] exp);
        if (issueBase + idx < issueQ.size())
            checkOutput("issue", {8'd0, issueQ[issueBase + idx]}, {8'd0, exp});
        else
            checkOutput("issue_missing", 32'd0, 32'd1);
    endtask

    task automatic checkSpacing(input int idxA, input int idxB, input int gap);
        if (fetchBase + idxB < fetchCyc.size())
            checkOutput("fetch_gap", fetchCyc[fetchBase + idxB] - fetchCyc[fetchBase + idxA], gap);
        else
            checkOutput("fetch_gap_missing", 32'd0, 32'd1);
    endtask

    initial begin
        // Reset state and idling without start.
        resetDut();
        checkOutput("rst_pc", {24'd0, pc}, 32'h00);
        checkOutput("rst_iaddr", {24'd0, iAddr}, 32'h00);
        checkOutput("rst_fetch", {31'd0, FETCH}, 32'd0);
        checkOutput("rst_valid", {31'd0, ir_valid}, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd0);
        checkOutput("rst_opcode", {24'd0, ir_opcode}, 32'h00);
        checkOutput("rst_operand", {24'd0, ir_operand}, 32'h00);
        repeat (3) tick();
        checkOutput("idle_no_fetch", fetchQ.size() - fetchBase, 32'd0);

        // Stream of 1-byte instructions ending in HALT.
        resetDut();
        for (int i = 0; i < 5; i++) mem[i] = 8'(i + 1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("lat_fetch", {31'd0, FETCH}, 32'd1);
        tick();
        tick();
        checkOutput("lat_valid", {31'd0, ir_valid}, 32'd1);
        waitHalted(100);
        for (int i = 0; i < 6; i++) checkFetchAt(i, 8'(i));
        for (int i = 0; i < 5; i++) checkSpacing(i, i + 1, 3);
        for (int i = 0; i < 5; i++) checkIssueAt(i, {8'(i + 1), 8'h00, 8'(i + 1)});
        checkOutput("s1_pc", {24'd0, pc}, 32'h06);
        repeat (4) tick();
        checkOutput("s1_fetch_off", {31'd0, FETCH}, 32'd0);
        checkOutput("s1_fetch_count", fetchQ.size() - fetchBase, 32'd6);

        // One 2-byte instruction then HALT.
        resetDut();
        mem[0] = 8'h81;
        mem[1] = 8'h3C;
        applyStimulus(1'b1, 1'b0, 8'h00);
        waitHalted(100);
        checkFetchAt(0, 8'h00);
        checkFetchAt(1, 8'h01);
        checkFetchAt(2, 8'h02);
        checkSpacing(0, 2, 5);
        checkIssueAt(0, 24'h813C02);
        checkOutput("s2_issue_count", issueQ.size() - issueBase, 32'd1);
        checkOutput("s2_pc", {24'd0, pc}, 32'h03);

        // Backpressure on the first issue.
        resetDut();
        for (int i = 0; i < 5; i++) mem[i] = 8'(i + 1);
        ir_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h00);
        waitValid(20);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_valid", {31'd0, ir_valid}, 32'd1);
            checkOutput("bp_opcode", {24'd0, ir_opcode}, 32'h01);
            checkOutput("bp_fetch", {31'd0, FETCH}, 32'd0);
            checkOutput("bp_pc", {24'd0, pc}, 32'h01);
        end
        ir_ready = 1'b1;
        tick();
        checkOutput("bp_resume_fetch", {31'd0, FETCH}, 32'd1);
        checkOutput("bp_resume_addr", {24'd0, iAddr}, 32'h01);
        waitHalted(100);

        // Jump during opcode capture, then a jump out of HALT.
        resetDut();
        for (int i = 0; i < 5; i++) mem[i] = 8'(i + 1);
        mem[8'h10] = 8'h07;
        applyStimulus(1'b1, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b1, 8'h10);
        checkOutput("jmp_fetch", {31'd0, FETCH}, 32'd1);
        checkOutput("jmp_addr", {24'd0, iAddr}, 32'h10);
        waitHalted(100);
        checkFetchAt(0, 8'h00);
        checkFetchAt(1, 8'h10);
        checkFetchAt(2, 8'h11);
        checkIssueAt(0, 24'h070011);
        checkOutput("jmp_issue_count", issueQ.size() - issueBase, 32'd1);
        checkOutput("jmp_pc", {24'd0, pc}, 32'h12);
        applyStimulus(1'b0, 1'b1, 8'h10);
        checkOutput("unhalt_halted", {31'd0, halted}, 32'd0);
        checkOutput("unhalt_fetch", {31'd0, FETCH}, 32'd1);
        checkOutput("unhalt_addr", {24'd0, iAddr}, 32'h10);
        waitHalted(100);

        // Jump from IDLE to FF; operand fetch wraps to 00.
        resetDut();
        mem[8'hFF] = 8'h81;
        mem[8'h00] = 8'h55;
        applyStimulus(1'b0, 1'b1, 8'hFF);
        waitHalted(100);
        checkFetchAt(0, 8'hFF);
        checkFetchAt(1, 8'h00);
        checkFetchAt(2, 8'h01);
        checkIssueAt(0, 24'h815501);
        checkOutput("wrap_pc", {24'd0, pc}, 32'h02);

        // Asynchronous reset during operand capture.
        resetDut();
        mem[0] = 8'h81;
        mem[1] = 8'h3C;
        applyStimulus(1'b1, 1'b0, 8'h00);
        repeat (3) tick();
        checkOutput("ar_pre_opcode", {24'd0, ir_opcode}, 32'h81);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ar_pc", {24'd0, pc}, 32'h00);
        checkOutput("ar_iaddr", {24'd0, iAddr}, 32'h00);
        checkOutput("ar_fetch", {31'd0, FETCH}, 32'd0);
        checkOutput("ar_opcode", {24'd0, ir_opcode}, 32'h00);
        checkOutput("ar_operand", {24'd0, ir_operand}, 32'h00);
        checkOutput("ar_valid", {31'd0, ir_valid}, 32'd0);
        checkOutput("ar_halted", {31'd0, halted}, 32'd0);
        tick();
        rst_n     = 1'b1;
        fetchBase = fetchQ.size();
        repeat (4) tick();
        checkOutput("ar_no_fetch", fetchQ.size() - fetchBase, 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("ar_restart_fetch", {31'd0, FETCH}, 32'd1);
        checkOutput("ar_restart_addr", {24'd0, iAddr}, 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
